// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: trace FIFO and event counters for the 5-stage RISC-V pipeline.
// Captures {stamp, flags, pc, instr} per retiring instruction, keeps saturating event
// counters, and has a PC-match trigger that freezes capture after post_cnt further records.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wb_valid/wb_pc/wb_instr     retiring instruction from WB
//   stall/flush/forwardA/B      hazard-unit debug signals
//   mem_write                   store in MEM this cycle
//   ring_mode                   1 = overwrite oldest when full, 0 = drop newest
//   trig_en/trig_pc/post_cnt    trigger setup; rearm returns FROZEN -> RUN
//   clr_cnt                     zero the event counters
//   rd_en/rd_valid/rd_data      show-ahead FIFO read port
//   count/lost                  occupancy and dropped-record count
//   cnt_sel/cnt_val             event counter readout
//   frozen                      trigger FSM is in FROZEN
module pipe_trace_buffer #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned STAMP_W = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wb_valid,
   input  logic [XLEN-1:0]               wb_pc,
   input  logic [XLEN-1:0]               wb_instr,
   input  logic                          stall,
   input  logic                          flush,
   input  logic [1:0]                    forwardA,
   input  logic [1:0]                    forwardB,
   input  logic                          mem_write,
   input  logic                          ring_mode,
   input  logic                          trig_en,
   input  logic [XLEN-1:0]               trig_pc,
   input  logic [$clog2(DEPTH):0]        post_cnt,
   input  logic                          rearm,
   input  logic                          clr_cnt,
   input  logic                          rd_en,
   output logic                          rd_valid,
   output logic [STAMP_W+5+2*XLEN-1:0]   rd_data,
   output logic [$clog2(DEPTH):0]        count,
   output logic [CNT_W-1:0]              lost,
   input  logic [2:0]                    cnt_sel,
   output logic [CNT_W-1:0]              cnt_val,
   output logic                          frozen
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned RW = STAMP_W + 5 + 2 * XLEN;
   localparam int unsigned NC = 6;

   typedef enum logic [1:0] {StRun, StPost, StFrozen} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       remain_q, remain_d;
   logic [STAMP_W-1:0]  stamp_q;
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       count_q;
   logic [CNT_W-1:0]    lost_q;
   logic [CNT_W-1:0]    cnt_q [NC];
   logic [RW-1:0]       mem_q [DEPTH];

   logic          capture, pop, full, wr_en, rd_adv;
   logic [NC-1:0] ev;
   logic [4:0]    flags;

   assign flags   = {stall, flush, |forwardA, |forwardB, mem_write};
   assign capture = wb_valid && (state_q != StFrozen);
   assign full    = (count_q == CW'(DEPTH));
   assign pop     = rd_en && (count_q != '0);
   // When full without a pop, only ring mode makes room by retiring the head.
   assign wr_en   = capture && (!full || pop || ring_mode);
   assign rd_adv  = pop || (capture && full && ring_mode);

   // Event conditions in cnt_sel order: cycles, retires, stalls, flushes, forwards, stores.
   assign ev = {mem_write, (|forwardA) || (|forwardB), flush, stall, wb_valid, 1'b1};

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {stamp_q, flags, wb_pc, wb_instr};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stamp_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         lost_q   <= '0;
      end else begin
         stamp_q <= stamp_q + 1'b1;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_adv) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (wr_en && !rd_adv) begin
            count_q <= count_q + 1'b1;
         end else if (!wr_en && rd_adv) begin
            count_q <= count_q - 1'b1;
         end
         if (capture && full && !pop && (lost_q != '1)) begin
            lost_q <= lost_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NC; i++) begin
         if (reset || clr_cnt) begin
            cnt_q[i] <= '0;
         end else if (ev[i] && (cnt_q[i] != '1)) begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StRun;
         remain_q <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      unique case (state_q)
         StRun: begin
            if (capture && trig_en && (wb_pc == trig_pc)) begin
               if (post_cnt == '0) begin
                  state_d = StFrozen;
               end else begin
                  state_d  = StPost;
                  remain_d = post_cnt;
               end
            end
         end
         StPost: begin
            // Dropped records also count: capture is independent of FIFO space.
            if (capture) begin
               remain_d = remain_q - 1'b1;
               if (remain_q == CW'(1)) begin
                  state_d = StFrozen;
               end
            end
         end
         StFrozen: begin
            if (rearm) begin
               state_d = StRun;
            end
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      cnt_val = '0;
      if (cnt_sel < 3'(NC)) begin
         cnt_val = cnt_q[cnt_sel];
      end
   end

   assign rd_valid = (count_q != '0);
   assign rd_data  = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign lost     = lost_q;
   assign frozen   = (state_q == StFrozen);

endmodule
